// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the CPU fetch path
// and the load/store path. One access at a time, fair tie-break between the
// two requesters, and a watchdog that turns a hung access into a bus error.
//
// Handshake semantics (all three ports):
//   - Requesters hold req high (level) with stable addr/we/wdata until their
//     one-cycle done pulse; on the edge ending the done cycle they either drop
//     req or present the next request. req still high in the following IDLE
//     cycle is a new access.
//   - Memory side: mem_req stays high with stable mem_we/mem_addr/mem_wdata
//     until the memory answers with a one-cycle mem_ready (mem_rdata valid in
//     that same cycle) or the watchdog expires. mem_ready is ignored whenever
//     no access is outstanding.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          RESET,
  // fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_err,
  // load/store port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_err,
  // memory port
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  // debug: current sequencer state (IDLE=0, BUSY=1, RESP=2)
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int              WDW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0]  WD_MAX  = {WDW{1'b1}};

  logic [1:0]     state;
  logic [WDW-1:0] wd;       // BUSY cycles elapsed without mem_ready
  logic           owner;    // 1 = data port owns the current access
  logic           last;     // 1 = data port was granted last (reset: fetch)
  logic           grant_d;  // IDLE arbitration result

  assign dbg_state = state;

  // Arbitration: a lone requester wins; on a tie the port not granted last wins.
  always_comb begin
    grant_d = d_req && (!if_req || !last);
  end

  // Sequencer: grant in IDLE, hold the access in BUSY, pulse done in RESP.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      last      <= 1'b0;
      wd        <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      if_err    <= 1'b0;
      d_err     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (if_req || d_req) begin
            owner     <= grant_d;
            last      <= grant_d;
            mem_req   <= 1'b1;
            mem_we    <= grant_d && d_we;   // fetches are always reads
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
            wd        <= '0;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= S_RESP;
            if (owner) begin
              d_done <= 1'b1;
              d_err  <= 1'b0;
              if (!mem_we) d_rdata <= mem_rdata;  // stores leave d_rdata alone
            end else begin
              if_done  <= 1'b1;
              if_err   <= 1'b0;
              if_rdata <= mem_rdata;
            end
          end else if (wd == WD_LAST) begin
            // Memory hung: abort and report a bus error with zeroed data.
            mem_req <= 1'b0;
            state   <= S_RESP;
            if (owner) begin
              d_done  <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end else begin
              if_done  <= 1'b1;
              if_err   <= 1'b1;
              if_rdata <= '0;
            end
          end else if (wd != WD_MAX) begin
            wd <= wd + WDW'(1);
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
